// File: rtl/adder_operand_packer_pkg.sv
// Shared constants and helpers for the 4-operand adder datapath.
package adder_operand_packer_pkg;

  // Operands per packed group (x, y, z, w).
  localparam int NUM_OPS = 4;

  // Width of an operand slot index.
  localparam int SLOT_W = $clog2(NUM_OPS);

  // Lowest bit of operand slot k inside a packed vector of w-bit words:
  // slot k occupies [(k+1)*w-1 : k*w].
  function automatic int op_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/adder_operand_packer_if.sv
// Operand stream in, packed group out: the packer's handshake bundle.
interface adder_operand_packer_if #(
  parameter int W = 8
);

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic           in_cin;
  logic           in_abort;
  logic [4*W-1:0] ins;
  logic           cin;
  logic           ins_valid;
  logic           ins_ready;

  // Packer side.
  modport slave (
    input  in_valid, in_data, in_cin, in_abort, ins_ready,
    output in_ready, ins, cin, ins_valid
  );

  // Producer/consumer side.
  modport master (
    output in_valid, in_data, in_cin, in_abort, ins_ready,
    input  in_ready, ins, cin, ins_valid
  );

endinterface

// File: rtl/adder_hold_stage.sv
// One-entry valid/ready holding register. A load and a drain on the same
// edge keeps the stage full with the newly loaded data.
module adder_hold_stage #(
  parameter int DW = 33
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          ready,
  output logic [DW-1:0] data,
  output logic          valid
);

  logic [DW-1:0] data_r;
  logic          valid_r;

  // Occupancy flag: set on load, cleared on drain without a refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b1;
    end else if (valid_r && ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Held payload: only a load changes it, so it is stable while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= {DW{1'b0}};
    end else if (load) begin
      data_r <= load_data;
    end else begin
      data_r <= data_r;
    end
  end

  assign data  = data_r;
  assign valid = valid_r;

endmodule

// File: rtl/adder_operand_packer.sv
// Packs four serial W-bit operand beats (x,y,z,w) plus carry-in into one
// 4*W vector held in a one-entry output stage. The closing beat loads the
// output stage directly, so the next group collects while one is held.
module adder_operand_packer
  import adder_operand_packer_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  adder_operand_packer_if.slave bus,
  output logic [2:0]       fill,
  output logic [CNT_W-1:0] grp_count
);

  localparam int HOLD_W = NUM_OPS * W + 1;

  logic [3*W-1:0]    asm_r;
  logic [2:0]        fill_r;
  logic [CNT_W-1:0]  grp_count_r;
  logic              ready_en_r;
  logic              in_ready_s;
  logic              accept_s;
  logic              load_s;
  logic              drain_s;
  logic [HOLD_W-1:0] load_data_s;
  logic [HOLD_W-1:0] hold_data_s;
  logic              hold_valid_s;

  // Only the closing beat can stall, and only when the held group is not
  // leaving this cycle. ready_en_r keeps in_ready low until the first edge
  // after reset release.
  assign in_ready_s = ready_en_r &&
                      !((fill_r == 3'd3) && hold_valid_s && !bus.ins_ready);
  assign accept_s   = bus.in_valid && in_ready_s;
  assign load_s     = accept_s && (fill_r == 3'd3) && !bus.in_abort;
  assign drain_s    = hold_valid_s && bus.ins_ready;
  assign load_data_s = {bus.in_cin, bus.in_data, asm_r};

  // Out-of-reset flag gating in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_r <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
    end
  end

  // Slot counter: abort wins over any beat accepted in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_r <= 3'd0;
    end else if (bus.in_abort) begin
      fill_r <= 3'd0;
    end else if (accept_s) begin
      if (fill_r == 3'd3) begin
        fill_r <= 3'd0;
      end else begin
        fill_r <= fill_r + 3'd1;
      end
    end else begin
      fill_r <= fill_r;
    end
  end

  // Assembly words x,y,z; w goes straight to the hold stage with cin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_r <= {(3*W){1'b0}};
    end else if (accept_s && !bus.in_abort) begin
      case (fill_r)
        3'd0:    asm_r[op_lsb(0, W) +: W] <= bus.in_data;
        3'd1:    asm_r[op_lsb(1, W) +: W] <= bus.in_data;
        3'd2:    asm_r[op_lsb(2, W) +: W] <= bus.in_data;
        default: asm_r <= asm_r;
      endcase
    end else begin
      asm_r <= asm_r;
    end
  end

  // Emitted-group counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp_count_r <= {CNT_W{1'b0}};
    end else if (drain_s) begin
      grp_count_r <= grp_count_r + CNT_W'(1);
    end else begin
      grp_count_r <= grp_count_r;
    end
  end

  adder_hold_stage #(
    .DW(HOLD_W)
  ) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_s),
    .load_data (load_data_s),
    .ready     (bus.ins_ready),
    .data      (hold_data_s),
    .valid     (hold_valid_s)
  );

  assign bus.in_ready  = in_ready_s;
  assign bus.ins       = hold_data_s[NUM_OPS*W-1:0];
  assign bus.cin       = hold_data_s[NUM_OPS*W];
  assign bus.ins_valid = hold_valid_s;
  assign fill          = fill_r;
  assign grp_count     = grp_count_r;

endmodule

// File: tb/tb_adder_operand_packer.sv
// Directed self-checking bench for adder_operand_packer. A second instance
// with a 4-bit group counter mirrors the stimulus to exercise counter wrap.
module tb_adder_operand_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  fill_a, fill_b;
  logic [15:0] grp_a;
  logic [3:0]  grp_b;
  int          errors = 0;
  int          checks = 0;
  int          exp_groups = 0;

  adder_operand_packer_if #(.W(8)) bus_a ();
  adder_operand_packer_if #(.W(8)) bus_b ();

  assign bus_b.in_valid  = bus_a.in_valid;
  assign bus_b.in_data   = bus_a.in_data;
  assign bus_b.in_cin    = bus_a.in_cin;
  assign bus_b.in_abort  = bus_a.in_abort;
  assign bus_b.ins_ready = bus_a.ins_ready;

  adder_operand_packer #(.W(8), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .fill(fill_a), .grp_count(grp_a));
  adder_operand_packer #(.W(8), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .fill(fill_b), .grp_count(grp_b));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic beat(input logic [7:0] d, input logic c, input logic ab);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = d;
    bus_a.in_cin   = c;
    bus_a.in_abort = ab;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_a.in_valid = 1'b0;
    bus_a.in_abort = 1'b0;
    bus_a.in_cin   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus_a.in_valid = 1'b0; bus_a.in_data = 8'h00; bus_a.in_cin = 1'b0;
    bus_a.in_abort = 1'b0; bus_a.ins_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus_a.ins !== 32'h0 || bus_a.cin !== 1'b0 || bus_a.ins_valid !== 1'b0 ||
        fill_a !== 3'd0 || grp_a !== 16'd0 || bus_a.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ins=%h cin=%b v=%b fill=%0d grp=%0d rdy=%b, want all 0",
               bus_a.ins, bus_a.cin, bus_a.ins_valid, fill_a, grp_a, bus_a.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus_a.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", bus_a.in_ready);
    end
  endtask

  task automatic test_basic();
    bus_a.ins_ready = 1'b1;
    beat(8'h01, 1'b0, 1'b0);
    checks++;
    if (fill_a !== 3'd1) begin
      errors++; $display("FAIL basic_fill1: got %0d want 1", fill_a);
    end
    beat(8'h02, 1'b0, 1'b0);
    beat(8'h03, 1'b0, 1'b0);
    checks++;
    if (fill_a !== 3'd3 || bus_a.ins_valid !== 1'b0) begin
      errors++; $display("FAIL basic_fill3: fill=%0d v=%b want 3/0", fill_a, bus_a.ins_valid);
    end
    beat(8'h04, 1'b1, 1'b0);
    checks++;
    if (bus_a.ins !== 32'h04030201 || bus_a.cin !== 1'b1 || bus_a.ins_valid !== 1'b1 ||
        fill_a !== 3'd0) begin
      errors++;
      $display("FAIL basic_group: ins=%h cin=%b v=%b fill=%0d want 04030201/1/1/0",
               bus_a.ins, bus_a.cin, bus_a.ins_valid, fill_a);
    end
    idle();
    exp_groups++;
    checks++;
    if (bus_a.ins_valid !== 1'b0 || grp_a !== 16'(exp_groups)) begin
      errors++;
      $display("FAIL basic_drain: v=%b grp=%0d want 0/%0d", bus_a.ins_valid, grp_a, exp_groups);
    end
  endtask

  task automatic test_backpressure();
    bus_a.ins_ready = 1'b0;
    beat(8'h10, 1'b0, 1'b0);
    beat(8'h11, 1'b0, 1'b0);
    beat(8'h12, 1'b0, 1'b0);
    beat(8'h13, 1'b0, 1'b0);
    beat(8'h14, 1'b0, 1'b0);
    beat(8'h15, 1'b0, 1'b0);
    beat(8'h16, 1'b0, 1'b0);
    checks++;
    if (bus_a.ins !== 32'h13121110 || bus_a.ins_valid !== 1'b1 || fill_a !== 3'd3) begin
      errors++;
      $display("FAIL bp_held: ins=%h v=%b fill=%0d want 13121110/1/3",
               bus_a.ins, bus_a.ins_valid, fill_a);
    end
    bus_a.in_data = 8'h17;
    #1;
    checks++;
    if (bus_a.in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_stall_ready: got %b want 0", bus_a.in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus_a.ins !== 32'h13121110 || fill_a !== 3'd3 || grp_a !== 16'(exp_groups)) begin
      errors++;
      $display("FAIL bp_stable: ins=%h fill=%0d grp=%0d want 13121110/3/%0d",
               bus_a.ins, fill_a, grp_a, exp_groups);
    end
    bus_a.ins_ready = 1'b1;
    #1;
    checks++;
    if (bus_a.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready: got %b want 1", bus_a.in_ready);
    end
    @(posedge clk);
    #1;
    exp_groups++;
    checks++;
    if (bus_a.ins !== 32'h17161514 || bus_a.ins_valid !== 1'b1 || grp_a !== 16'(exp_groups)) begin
      errors++;
      $display("FAIL bp_load_drain: ins=%h v=%b grp=%0d want 17161514/1/%0d",
               bus_a.ins, bus_a.ins_valid, grp_a, exp_groups);
    end
    idle();
    exp_groups++;
    checks++;
    if (bus_a.ins_valid !== 1'b0 || grp_a !== 16'(exp_groups)) begin
      errors++;
      $display("FAIL bp_drain2: v=%b grp=%0d want 0/%0d", bus_a.ins_valid, grp_a, exp_groups);
    end
  endtask

  task automatic test_abort();
    bus_a.ins_ready = 1'b1;
    beat(8'hAA, 1'b0, 1'b0);
    beat(8'hBB, 1'b0, 1'b0);
    beat(8'hCC, 1'b0, 1'b1);
    checks++;
    if (fill_a !== 3'd0 || bus_a.ins_valid !== 1'b0) begin
      errors++; $display("FAIL abort_fill: fill=%0d v=%b want 0/0", fill_a, bus_a.ins_valid);
    end
    beat(8'h01, 1'b0, 1'b0);
    beat(8'h02, 1'b0, 1'b0);
    beat(8'h03, 1'b0, 1'b0);
    beat(8'h04, 1'b0, 1'b0);
    checks++;
    if (bus_a.ins !== 32'h04030201 || bus_a.cin !== 1'b0 || bus_a.ins_valid !== 1'b1) begin
      errors++;
      $display("FAIL abort_fresh: ins=%h cin=%b v=%b want 04030201/0/1",
               bus_a.ins, bus_a.cin, bus_a.ins_valid);
    end
    idle();
    exp_groups++;
    beat(8'h31, 1'b0, 1'b0);
    beat(8'h32, 1'b0, 1'b0);
    beat(8'h33, 1'b0, 1'b0);
    beat(8'h34, 1'b1, 1'b1);
    checks++;
    if (bus_a.ins_valid !== 1'b0 || fill_a !== 3'd0 || bus_a.ins !== 32'h04030201 ||
        grp_a !== 16'(exp_groups)) begin
      errors++;
      $display("FAIL abort_last_beat: v=%b fill=%0d ins=%h grp=%0d want 0/0/04030201/%0d",
               bus_a.ins_valid, fill_a, bus_a.ins, grp_a, exp_groups);
    end
    idle();
  endtask

  task automatic test_cin_max();
    bus_a.ins_ready = 1'b1;
    beat(8'h21, 1'b1, 1'b0);
    beat(8'h22, 1'b1, 1'b0);
    beat(8'h23, 1'b1, 1'b0);
    beat(8'h24, 1'b0, 1'b0);
    checks++;
    if (bus_a.ins !== 32'h24232221 || bus_a.cin !== 1'b0) begin
      errors++;
      $display("FAIL cin_last_only: ins=%h cin=%b want 24232221/0", bus_a.ins, bus_a.cin);
    end
    beat(8'hFF, 1'b0, 1'b0);
    beat(8'hFF, 1'b0, 1'b0);
    beat(8'hFF, 1'b0, 1'b0);
    beat(8'hFF, 1'b1, 1'b0);
    exp_groups += 2;
    checks++;
    if (bus_a.ins !== 32'hFFFFFFFF || bus_a.cin !== 1'b1 || bus_a.ins_valid !== 1'b1) begin
      errors++;
      $display("FAIL max_words: ins=%h cin=%b v=%b want FFFFFFFF/1/1",
               bus_a.ins, bus_a.cin, bus_a.ins_valid);
    end
    idle();
  endtask

  task automatic stream(input int ngroups, input string tag);
    logic [7:0]  b;
    logic [31:0] exp_ins;
    bus_a.ins_ready = 1'b1;
    for (int i = 0; i < ngroups * 4; i++) begin
      b = 8'(i);
      beat(b, 1'b0, 1'b0);
      checks++;
      if (bus_a.ins_valid !== ((i % 4) == 3)) begin
        errors++;
        $display("FAIL %s_valid_beat%0d: got %b want %b", tag, i, bus_a.ins_valid, (i % 4) == 3);
      end
      if ((i % 4) == 3) begin
        exp_ins = {8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)};
        checks++;
        if (bus_a.ins !== exp_ins) begin
          errors++;
          $display("FAIL %s_data_beat%0d: got %h want %h", tag, i, bus_a.ins, exp_ins);
        end
      end
    end
    idle();
    exp_groups += ngroups;
  endtask

  task automatic test_stream();
    stream(20, "stream");
    checks++;
    if (grp_a !== 16'(exp_groups)) begin
      errors++; $display("FAIL stream_count: got %0d want %0d", grp_a, exp_groups);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_groups = 0;
    stream(17, "wrap");
    checks++;
    if (grp_b !== 4'd1 || grp_a !== 16'd17) begin
      errors++;
      $display("FAIL wrap_count: cnt4=%0d cnt16=%0d want 1/17", grp_b, grp_a);
    end
  endtask

  task automatic test_reset_mid();
    bus_a.ins_ready = 1'b0;
    beat(8'h51, 1'b1, 1'b0);
    beat(8'h52, 1'b1, 1'b0);
    beat(8'h53, 1'b1, 1'b0);
    beat(8'h54, 1'b1, 1'b0);
    beat(8'h55, 1'b0, 1'b0);
    beat(8'h56, 1'b0, 1'b0);
    idle();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus_a.ins !== 32'h0 || bus_a.cin !== 1'b0 || bus_a.ins_valid !== 1'b0 ||
        fill_a !== 3'd0 || grp_a !== 16'd0 || bus_a.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: ins=%h cin=%b v=%b fill=%0d grp=%0d rdy=%b want all 0",
               bus_a.ins, bus_a.cin, bus_a.ins_valid, fill_a, grp_a, bus_a.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus_a.in_ready !== 1'b0) begin
      errors++; $display("FAIL midreset_ready_pre: got %b want 0", bus_a.in_ready);
    end
    @(posedge clk);
    #1;
    bus_a.ins_ready = 1'b1;
    beat(8'h41, 1'b0, 1'b0);
    beat(8'h42, 1'b0, 1'b0);
    beat(8'h43, 1'b0, 1'b0);
    beat(8'h44, 1'b0, 1'b0);
    checks++;
    if (bus_a.ins !== 32'h44434241 || bus_a.cin !== 1'b0 || bus_a.ins_valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_fresh: ins=%h cin=%b v=%b want 44434241/0/1",
               bus_a.ins, bus_a.cin, bus_a.ins_valid);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_abort();
    test_cin_max();
    test_stream();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
